// File: rtl/coproc_pkg.sv
// Shared definitions for the HPS PIO command responder: opcodes, instruction
// field positions and the command FSM state encoding.
package coproc_pkg;

  localparam int IMG_ADDR_W = 15;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 3;
  localparam int ADDR_LSB = 3;
  localparam int ADDR_W   = IMG_ADDR_W;
  localparam int PIX_LSB  = 18;
  localparam int PIX_W    = 8;

  localparam logic [OPC_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OPC_W-1:0] OP_WRITE = 3'b001;
  localparam logic [OPC_W-1:0] OP_CRST  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_WRITE,
    ST_RUN,
    ST_CRST,
    ST_RESP,
    ST_WAIT_REL
  } state_t;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Cycle counter shared by the write-commit wait, algorithm timeout and core
// reset pulse; o_expire flags the enabled cycle that completes i_limit counts.
module cmd_timeout_counter #(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expire
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_expire = i_en && (r_cnt == (i_limit - ONE));

endmodule

// File: rtl/pio_cmd_responder.sv
// HPS PIO command responder: latches an instruction on a start edge, performs
// a pixel write, algorithm run or core reset, then answers with a 4-phase handshake.
module pio_cmd_responder
  import coproc_pkg::*;
#(
  parameter int IMG_PIXELS      = 19200,
  parameter int WR_LATENCY      = 2,
  parameter int ALG_TIMEOUT     = 2**20,
  parameter int CORE_RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           instr_i,
  input  logic                  start_i,
  output logic                  done_o,
  output logic                  donewrite_o,
  output logic                  err_o,
  output logic                  mem_wr_en_o,
  output logic [IMG_ADDR_W-1:0] mem_addr_o,
  output logic [7:0]            mem_wdata_o,
  output logic                  alg_start_o,
  output logic [2:0]            alg_sel_o,
  input  logic                  alg_done_i,
  output logic                  core_rst_o
);

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  localparam int CNT_W = $clog2(max3(WR_LATENCY, ALG_TIMEOUT, CORE_RST_CYCLES) + 1);

  state_t            r_state;
  logic              r_start_q;
  logic [31:0]       r_instr;

  logic [OPC_W-1:0]  w_opcode;
  logic [ADDR_W-1:0] w_addr;
  logic [PIX_W-1:0]  w_pixel;
  logic              w_addr_bad;
  logic              w_cnt_load;
  logic              w_cnt_en;
  logic [CNT_W-1:0]  w_limit;
  logic              w_expire;

  assign w_opcode   = r_instr[OPC_LSB  +: OPC_W];
  assign w_addr     = r_instr[ADDR_LSB +: ADDR_W];
  assign w_pixel    = r_instr[PIX_LSB  +: PIX_W];
  assign w_addr_bad = ({17'd0, w_addr} >= 32'(IMG_PIXELS));

  assign w_cnt_load = (r_state == ST_DECODE);
  assign w_cnt_en   = (r_state == ST_WRITE) || (r_state == ST_RUN) || (r_state == ST_CRST);

  always_comb begin
    w_limit = CNT_W'(WR_LATENCY);
    case (r_state)
      ST_RUN:  w_limit = CNT_W'(ALG_TIMEOUT);
      ST_CRST: w_limit = CNT_W'(CORE_RST_CYCLES);
      default: w_limit = CNT_W'(WR_LATENCY);
    endcase
  end

  cmd_timeout_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_cnt_load),
    .i_en     (w_cnt_en),
    .i_limit  (w_limit),
    .o_expire (w_expire)
  );

  // start_q resets high so a start level already present at reset exit is not an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_start_q   <= 1'b1;
      r_instr     <= '0;
      done_o      <= 1'b0;
      donewrite_o <= 1'b0;
      err_o       <= 1'b0;
      mem_wr_en_o <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      alg_start_o <= 1'b0;
      alg_sel_o   <= '0;
      core_rst_o  <= 1'b0;
    end else begin
      r_start_q <= start_i;
      case (r_state)
        ST_IDLE: begin
          if (start_i && !r_start_q) begin
            r_instr <= instr_i;
            err_o   <= 1'b0;
            r_state <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_opcode == OP_NOP) begin
            r_state <= ST_RESP;
          end else if (w_opcode == OP_WRITE) begin
            if (w_addr_bad) begin
              err_o   <= 1'b1;
              r_state <= ST_RESP;
            end else begin
              mem_wr_en_o <= 1'b1;
              mem_addr_o  <= w_addr;
              mem_wdata_o <= w_pixel;
              r_state     <= ST_WRITE;
            end
          end else if (w_opcode == OP_CRST) begin
            core_rst_o <= 1'b1;
            r_state    <= ST_CRST;
          end else begin
            alg_start_o <= 1'b1;
            alg_sel_o   <= w_opcode;
            r_state     <= ST_RUN;
          end
        end
        ST_WRITE: begin
          mem_wr_en_o <= 1'b0;
          if (w_expire) r_state <= ST_RESP;
        end
        ST_RUN: begin
          // a completion seen during the start pulse cycle belongs to no request of ours
          alg_start_o <= 1'b0;
          if (!alg_start_o && alg_done_i) begin
            r_state <= ST_RESP;
          end else if (w_expire) begin
            err_o   <= 1'b1;
            r_state <= ST_RESP;
          end
        end
        ST_CRST: begin
          if (w_expire) begin
            core_rst_o <= 1'b0;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_opcode == OP_WRITE) donewrite_o <= 1'b1;
          else                      done_o      <= 1'b1;
          r_state <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (!start_i) begin
            done_o      <= 1'b0;
            donewrite_o <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pio_cmd_responder.sv
// Bench for pio_cmd_responder: directed scenarios plus randomized commands
// checked against a protocol-level model of expected responses.
module tb_pio_cmd_responder;

  localparam int IMG_PIXELS      = 19200;
  localparam int WR_LATENCY      = 2;
  localparam int ALG_TIMEOUT     = 64;
  localparam int CORE_RST_CYCLES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_i;
  logic        start_i;
  logic        done_o;
  logic        donewrite_o;
  logic        err_o;
  logic        mem_wr_en_o;
  logic [14:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        alg_start_o;
  logic [2:0]  alg_sel_o;
  logic        alg_done_i;
  logic        core_rst_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pio_cmd_responder #(
    .IMG_PIXELS      (IMG_PIXELS),
    .WR_LATENCY      (WR_LATENCY),
    .ALG_TIMEOUT     (ALG_TIMEOUT),
    .CORE_RST_CYCLES (CORE_RST_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_i     (instr_i),
    .start_i     (start_i),
    .done_o      (done_o),
    .donewrite_o (donewrite_o),
    .err_o       (err_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .alg_start_o (alg_start_o),
    .alg_sel_o   (alg_sel_o),
    .alg_done_i  (alg_done_i),
    .core_rst_o  (core_rst_o)
  );

  // Event monitor: counts strobes/pulses observed on the DUT outputs
  int          wr_cnt     = 0;
  int          alg_cnt    = 0;
  int          crst_cyc   = 0;
  logic [14:0] last_addr  = '0;
  logic [7:0]  last_data  = '0;

  always @(negedge clk) begin
    if (mem_wr_en_o) begin
      wr_cnt    <= wr_cnt + 1;
      last_addr <= mem_addr_o;
      last_data <= mem_wdata_o;
    end
    if (alg_start_o) alg_cnt  <= alg_cnt + 1;
    if (core_rst_o)  crst_cyc <= crst_cyc + 1;
  end

  function automatic logic [31:0] mk(input logic [2:0] op, input int addr,
                                     input logic [7:0] pix, input logic [5:0] rsv);
    logic [14:0] a;
    a = addr[14:0];
    return {rsv, pix, a, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trigger(input logic [31:0] ins);
    start_i = 1'b0;
    tick();
    instr_i = ins;
    start_i = 1'b1;
    tick();
  endtask

  task automatic wait_resp(input int bound, output int n);
    n = 0;
    while (!(done_o || donewrite_o) && n < bound) begin
      tick();
      n++;
    end
  endtask

  task automatic release_start();
    start_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    logic [33:0] outs;
    int w0;
    reset = 1'b1; start_i = 1'b1; alg_done_i = 1'b0;
    instr_i = mk(3'b001, 5, 8'h11, 6'h0);
    tick(); tick();
    outs = {done_o, donewrite_o, err_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
            alg_start_o, alg_sel_o, core_rst_o};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    w0 = wr_cnt;
    reset = 1'b0;
    repeat (8) tick();
    tests_run++;
    if ((wr_cnt - w0) !== 0 || donewrite_o !== 1'b0 || done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_start_high: writes=%0d donewrite=%b done=%b expected no op",
               wr_cnt - w0, donewrite_o, done_o);
    end
  endtask

  task automatic test_nop();
    int n;
    trigger(32'h0);
    wait_resp(10, n);
    tests_run++;
    if (n !== 2 || done_o !== 1'b1 || donewrite_o !== 1'b0 || err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL nop_latency: n=%0d done=%b dw=%b err=%b expected n=2 done=1 dw=0 err=0",
               n, done_o, donewrite_o, err_o);
    end
    repeat (3) tick();
    tests_run++;
    if (done_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL nop_hold: done=%b expected 1 while start high", done_o);
    end
    start_i = 1'b0;
    tick();
    tests_run++;
    if (done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL nop_release: done=%b expected 0", done_o);
    end
    tick();
  endtask

  task automatic test_write();
    int n, w0;
    w0 = wr_cnt;
    trigger(mk(3'b001, 100, 8'hA5, 6'h2A));
    wait_resp(20, n);
    tests_run++;
    if (n !== 2 + WR_LATENCY || donewrite_o !== 1'b1 || done_o !== 1'b0 || err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL write_resp: n=%0d dw=%b done=%b err=%b expected n=%0d dw=1 done=0 err=0",
               n, donewrite_o, done_o, err_o, 2 + WR_LATENCY);
    end
    tests_run++;
    if ((wr_cnt - w0) !== 1 || last_addr !== 15'd100 || last_data !== 8'hA5) begin
      tests_failed++;
      $display("FAIL write_strobe: count=%0d addr=%0d data=%h expected 1/100/a5",
               wr_cnt - w0, last_addr, last_data);
    end
    release_start();
  endtask

  task automatic test_bad_addr();
    int addrs[3] = '{19200, 32767, 19199};
    int n, w0, exp_w;
    logic exp_err;
    foreach (addrs[i]) begin
      exp_err = (addrs[i] >= IMG_PIXELS);
      exp_w   = exp_err ? 0 : 1;
      w0 = wr_cnt;
      trigger(mk(3'b001, addrs[i], 8'h3C, 6'h0));
      wait_resp(20, n);
      tests_run++;
      if (donewrite_o !== 1'b1 || err_o !== exp_err || (wr_cnt - w0) !== exp_w) begin
        tests_failed++;
        $display("FAIL bad_addr_%0d: dw=%b err=%b writes=%0d expected dw=1 err=%b writes=%0d",
                 addrs[i], donewrite_o, err_o, wr_cnt - w0, exp_err, exp_w);
      end
      release_start();
    end
  endtask

  task automatic test_alg();
    int n, a0;
    a0 = alg_cnt;
    trigger(mk(3'b011, 0, 8'h0, 6'h0));
    repeat (50) tick();
    alg_done_i = 1'b1;
    tick();
    alg_done_i = 1'b0;
    wait_resp(10, n);
    tests_run++;
    if (n !== 1 || done_o !== 1'b1 || err_o !== 1'b0 || alg_sel_o !== 3'd3) begin
      tests_failed++;
      $display("FAIL alg_run: n=%0d done=%b err=%b sel=%0d expected n=1 done=1 err=0 sel=3",
               n, done_o, err_o, alg_sel_o);
    end
    tests_run++;
    if ((alg_cnt - a0) !== 1) begin
      tests_failed++;
      $display("FAIL alg_pulse: pulse cycles=%0d expected 1", alg_cnt - a0);
    end
    release_start();
  endtask

  task automatic test_alg_same_cycle_done();
    int n;
    trigger(mk(3'b101, 0, 8'h0, 6'h0));
    tick();
    alg_done_i = 1'b1;
    tick();
    alg_done_i = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (done_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL alg_same_cycle: done=%b expected 0 (completion during pulse)", done_o);
    end
    alg_done_i = 1'b1;
    tick();
    alg_done_i = 1'b0;
    wait_resp(10, n);
    tests_run++;
    if (n !== 1 || done_o !== 1'b1 || alg_sel_o !== 3'd5) begin
      tests_failed++;
      $display("FAIL alg_late_done: n=%0d done=%b sel=%0d expected n=1 done=1 sel=5",
               n, done_o, alg_sel_o);
    end
    release_start();
  endtask

  task automatic test_timeout();
    int n;
    logic [2:0] op;
    op = 3'($urandom_range(2, 6));
    trigger(mk(op, 0, 8'h0, 6'h0));
    wait_resp(ALG_TIMEOUT + 20, n);
    tests_run++;
    if (n < ALG_TIMEOUT || n > ALG_TIMEOUT + 3 || done_o !== 1'b1 || err_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL alg_timeout: n=%0d done=%b err=%b expected n in [%0d,%0d] done=1 err=1",
               n, done_o, err_o, ALG_TIMEOUT, ALG_TIMEOUT + 3);
    end
    release_start();
  endtask

  task automatic test_crst();
    int n, c0;
    c0 = crst_cyc;
    trigger(mk(3'b111, 0, 8'h0, 6'h0));
    wait_resp(30, n);
    tests_run++;
    if ((crst_cyc - c0) !== CORE_RST_CYCLES || done_o !== 1'b1 || err_o !== 1'b0 ||
        core_rst_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL core_reset: pulse=%0d done=%b err=%b rst=%b expected %0d/1/0/0",
               crst_cyc - c0, done_o, err_o, core_rst_o, CORE_RST_CYCLES);
    end
    release_start();
  endtask

  task automatic test_alg_done_idle();
    alg_done_i = 1'b1;
    tick();
    alg_done_i = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (done_o !== 1'b0 || err_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL alg_done_idle: done=%b err=%b expected 0/0", done_o, err_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [33:0] outs;
    int a0;
    trigger(mk(3'b100, 0, 8'h0, 6'h0));
    repeat (5) tick();
    a0 = alg_cnt;
    reset = 1'b1;
    tick();
    outs = {done_o, donewrite_o, err_o, mem_wr_en_o, mem_addr_o, mem_wdata_o,
            alg_start_o, alg_sel_o, core_rst_o};
    tests_run++;
    if (outs !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: outputs=%h expected 0", outs);
    end
    reset = 1'b0;
    tick();
    alg_done_i = 1'b1;
    tick();
    alg_done_i = 1'b0;
    repeat (10) tick();
    tests_run++;
    if (done_o !== 1'b0 || (alg_cnt - a0) !== 0) begin
      tests_failed++;
      $display("FAIL reset_discard: done=%b new_pulses=%0d expected 0/0", done_o, alg_cnt - a0);
    end
    release_start();
  endtask

  task automatic test_start_drop();
    int n, w0;
    int addr;
    logic [7:0] pix;
    addr = $urandom_range(0, IMG_PIXELS - 1);
    pix  = 8'($urandom);
    w0 = wr_cnt;
    trigger(mk(3'b001, addr, pix, 6'h0));
    start_i = 1'b0;
    wait_resp(20, n);
    tests_run++;
    if (n !== 2 + WR_LATENCY || donewrite_o !== 1'b1 || (wr_cnt - w0) !== 1 ||
        last_addr !== addr[14:0] || last_data !== pix) begin
      tests_failed++;
      $display("FAIL start_drop: n=%0d dw=%b writes=%0d addr=%0d data=%h expected %0d/1/1/%0d/%h",
               n, donewrite_o, wr_cnt - w0, last_addr, last_data, 2 + WR_LATENCY, addr, pix);
    end
    tick();
    tests_run++;
    if (donewrite_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_drop_pulse: dw=%b expected 0 after one cycle", donewrite_o);
    end
    tick();
  endtask

  task automatic test_random();
    int n, k, d, w0, c0, exp_w, exp_lat, addr;
    logic [2:0] op;
    logic [7:0] pix;
    logic exp_err, exp_dw, ok;
    for (int it = 0; it < 30; it++) begin
      op   = 3'($urandom_range(0, 7));
      addr = ($urandom_range(0, 3) == 0) ? $urandom_range(IMG_PIXELS, 32767)
                                         : $urandom_range(0, IMG_PIXELS - 1);
      pix  = 8'($urandom);
      exp_dw  = (op == 3'b001);
      exp_err = exp_dw && (addr >= IMG_PIXELS);
      exp_w   = (exp_dw && !exp_err) ? 1 : 0;
      exp_lat = exp_w ? 2 + WR_LATENCY : 2;
      w0 = wr_cnt;
      c0 = crst_cyc;
      trigger(mk(op, addr, pix, 6'($urandom)));
      ok = 1'b1;
      if (op >= 3'd2 && op <= 3'd6) begin
        k = 0;
        while (!alg_start_o && k < 10) begin
          tick();
          k++;
        end
        if (alg_sel_o !== op) ok = 1'b0;
        d = $urandom_range(1, 40);
        repeat (d) tick();
        alg_done_i = 1'b1;
        tick();
        alg_done_i = 1'b0;
        wait_resp(10, n);
        if (n !== 1) ok = 1'b0;
      end else if (op == 3'b111) begin
        wait_resp(40, n);
        if ((crst_cyc - c0) !== CORE_RST_CYCLES) ok = 1'b0;
      end else begin
        wait_resp(20, n);
        if (n !== exp_lat) ok = 1'b0;
      end
      if (exp_w == 1 && (last_addr !== addr[14:0] || last_data !== pix)) ok = 1'b0;
      tests_run++;
      if (!ok || donewrite_o !== exp_dw || done_o !== !exp_dw || err_o !== exp_err ||
          (wr_cnt - w0) !== exp_w) begin
        tests_failed++;
        $display("FAIL random_%0d op=%0d addr=%0d: n=%0d dw=%b done=%b err=%b writes=%0d sel=%0d expected dw=%b err=%b writes=%0d",
                 it, op, addr, n, donewrite_o, done_o, err_o, wr_cnt - w0, alg_sel_o,
                 exp_dw, exp_err, exp_w);
      end
      release_start();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start_i = 1'b0; instr_i = '0; alg_done_i = 1'b0;
    test_reset();
    test_nop();
    test_write();
    test_bad_addr();
    test_alg();
    test_alg_same_cycle_done();
    test_timeout();
    test_crst();
    test_alg_done_idle();
    test_reset_mid_run();
    test_start_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
